// File: rtl/led_frame_scheduler.sv
// WS2812 frame sequencer: emits one GRB word per LED on a valid/ready handshake,
// then holds the strip latch gap before the next frame.
module led_frame_scheduler #(
  parameter int         NUM_LEDS        = 100,
  parameter int         POS_W           = 8,
  parameter int         LATCH_CLK_COUNT = 15000,
  parameter logic [7:0] BRIGHTNESS      = 8'h20,
  localparam int        IDX_W           = $clog2(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_in_menu,
  input  logic [2:0]       countdown,
  input  logic [POS_W-1:0] green_pos,
  input  logic [POS_W-1:0] red_pos,
  input  logic [POS_W-1:0] blue_pos,
  input  logic [POS_W-1:0] yellow_pos,
  input  logic             pixel_ready,
  output logic             pixel_valid,
  output logic [23:0]      pixel_grb,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int               CMP_W    = (POS_W > IDX_W) ? POS_W : IDX_W;
  localparam int               CNT_W    = $clog2(LATCH_CLK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CLK_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {S_LATCH, S_FRAME_START, S_SEND} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rr;
  logic [IDX_W-1:0] r_idx;
  logic [23:0]      r_grb;
  logic             r_menu_snap;
  logic [2:0]       r_cd_snap;
  logic [POS_W-1:0] r_g_snap;
  logic [POS_W-1:0] r_r_snap;
  logic [POS_W-1:0] r_b_snap;
  logic [POS_W-1:0] r_y_snap;
  logic             w_send;
  logic             w_hs;
  logic             w_last;

  // Colour of one LED; the round-robin scan starts at rr so a shared LED rotates owners.
  function automatic logic [23:0] f_pixel(
    input logic             menu,
    input logic [2:0]       cd,
    input logic [POS_W-1:0] g,
    input logic [POS_W-1:0] r,
    input logic [POS_W-1:0] b,
    input logic [POS_W-1:0] y,
    input logic [1:0]       rr,
    input logic [IDX_W-1:0] idx
  );
    logic [CMP_W-1:0] w_i;
    logic [3:0]       w_cov;
    logic [1:0]       w_p;
    logic             w_found;
    logic [23:0]      w_col;
    w_i     = CMP_W'(idx);
    w_cov   = {CMP_W'(y) == w_i, CMP_W'(b) == w_i, CMP_W'(r) == w_i, CMP_W'(g) == w_i};
    w_found = 1'b0;
    w_col   = 24'h0;
    w_p     = 2'd0;
    if (menu) begin
      if (32'(idx) < 32'(cd)) w_col = {BRIGHTNESS, BRIGHTNESS, BRIGHTNESS};
    end else begin
      for (int k = 0; k < 4; k++) begin
        w_p = rr + 2'(k);
        if (!w_found && w_cov[w_p]) begin
          w_found = 1'b1;
          case (w_p)
            2'd0:    w_col = {BRIGHTNESS, 8'h00, 8'h00};
            2'd1:    w_col = {8'h00, BRIGHTNESS, 8'h00};
            2'd2:    w_col = {8'h00, 8'h00, BRIGHTNESS};
            default: w_col = {BRIGHTNESS, BRIGHTNESS, 8'h00};
          endcase
        end
      end
    end
    return w_col;
  endfunction

  assign w_send      = (r_state == S_SEND);
  assign w_hs        = w_send & pixel_ready;
  assign w_last      = (r_idx == IDX_LAST);
  assign pixel_valid = w_send;
  assign pixel_grb   = r_grb;
  assign pixel_index = r_idx;
  assign frame_start = (r_state == S_FRAME_START);
  assign frame_done  = w_hs & w_last;
  assign busy        = (r_state == S_FRAME_START) | w_send;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LATCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LATCH:       if (r_cnt == CNT_LAST) w_next = S_FRAME_START;
      S_FRAME_START: w_next = S_SEND;
      S_SEND:        if (w_hs && w_last) w_next = S_LATCH;
      default:       w_next = S_LATCH;
    endcase
  end

  // Pixel 0 is built from the live inputs on the same edge that snapshots them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_rr  <= 2'd0;
      r_idx <= '0;
      r_grb <= 24'h0;
    end else begin
      case (r_state)
        S_LATCH: r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        S_FRAME_START: begin
          r_idx <= '0;
          r_grb <= f_pixel(is_in_menu, countdown, green_pos, red_pos, blue_pos,
                           yellow_pos, r_rr, {IDX_W{1'b0}});
        end
        S_SEND: begin
          if (w_hs) begin
            if (w_last) begin
              r_idx <= '0;
              r_grb <= 24'h0;
              r_rr  <= r_rr + 2'd1;
            end else begin
              r_idx <= IDX_W'(r_idx + 1'b1);
              r_grb <= f_pixel(r_menu_snap, r_cd_snap, r_g_snap, r_r_snap, r_b_snap,
                               r_y_snap, r_rr, IDX_W'(r_idx + 1'b1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FRAME_START) begin
      r_menu_snap <= is_in_menu;
      r_cd_snap   <= countdown;
      r_g_snap    <= green_pos;
      r_r_snap    <= red_pos;
      r_b_snap    <= blue_pos;
      r_y_snap    <= yellow_pos;
    end
  end

endmodule
